// File: rtl/mem_block_copier.sv
// Bus initiator that copies a block of consecutive words from a source to a
// destination address over the shared CPU memory bus (read, capture, write).
module mem_block_copier #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 9,
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] out,
    input  logic [DW-1:0] read_data,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_D = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [DW-1:0] data_d;
    logic [1:0]    cmd_d;
    logic [AW-1:0] addr_d;
    logic          busy_d;
    logic          done_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: three cycles per word, then a one-cycle DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (len == '0) ? DONE : RD_A;
            RD_A: state_d = RD_D;
            RD_D: state_d = WR;
            WR:   state_d = (rem_q == LW'(1)) ? DONE : RD_A;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch args on accept, capture read word, step after write
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        rem_d  = rem_q;
        data_d = out;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    rem_d = len;
                end
            end
            RD_D: data_d = read_data;
            WR: begin
                src_d = src_q + AW'(1);
                dst_d = dst_q + AW'(1);
                rem_d = rem_q - LW'(1);
            end
            default: ;
        endcase
    end

    // Output next values, decoded from the state being entered so outputs align with it
    always_comb begin
        cmd_d  = MNONE;
        addr_d = mem_addr;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            RD_A: begin
                cmd_d  = MREAD;
                addr_d = src_d;
                busy_d = 1'b1;
            end
            RD_D: begin
                cmd_d  = MREAD;
                addr_d = src_q;
                busy_d = 1'b1;
            end
            WR: begin
                cmd_d  = MWRITE;
                addr_d = dst_q;
                busy_d = 1'b1;
            end
            DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath and output registers; the captured word register drives the write data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            out      <= '0;
            mem_cmd  <= MNONE;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            out      <= data_d;
            mem_cmd  <= cmd_d;
            mem_addr <= addr_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule
